// File: rtl/keypad_scan4x4.sv
// rtl/keypad_scan4x4.sv - 4x4 hex keypad column scanner with debounce and 16-bit key history
module keypad_scan4x4 #(
   parameter int SCAN_DIV       = 250000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [3:0]  key,
   output logic        key_valid,
   output logic        key_down,
   output logic [15:0] value
);

   localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] TC   = CW'(SCAN_DIV - 1);
   localparam int            DW   = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW:0]   DS_W = (DW + 1)'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

   state_t        state, state_nx;
   logic [3:0]    row_meta, row_sync;
   logic [CW-1:0] cnt;
   logic [1:0]    col_idx;
   logic          hit_valid;
   logic [3:0]    hit_code;
   logic [3:0]    cand, cand_nx;
   logic [DW-1:0] dcnt, dcnt_nx;
   logic [DW:0]   dcnt_inc;
   logic          tc, scan_done, cur_hit, scan_hit, accept;
   logic [3:0]    cur_code, scan_code;

   // Lowest active row wins; rows are active-low.
   function automatic logic [3:0] key_code(input logic [1:0] c, input logic [3:0] r);
      logic [1:0] ri;
      ri = 2'd3;
      for (int i = 3; i >= 0; i--)
         if (!r[i]) ri = 2'(i);
      case ({ri, c})
         4'b0000: key_code = 4'h1;
         4'b0001: key_code = 4'h2;
         4'b0010: key_code = 4'h3;
         4'b0011: key_code = 4'hA;
         4'b0100: key_code = 4'h4;
         4'b0101: key_code = 4'h5;
         4'b0110: key_code = 4'h6;
         4'b0111: key_code = 4'hB;
         4'b1000: key_code = 4'h7;
         4'b1001: key_code = 4'h8;
         4'b1010: key_code = 4'h9;
         4'b1011: key_code = 4'hC;
         4'b1100: key_code = 4'h0;
         4'b1101: key_code = 4'hF;
         4'b1110: key_code = 4'hE;
         default: key_code = 4'hD;
      endcase
   endfunction

   assign tc        = (cnt == TC);
   assign scan_done = tc && (col_idx == 2'd3);
   assign cur_hit   = (row_sync != 4'hF);
   assign cur_code  = key_code(col_idx, row_sync);
   // The current column's sample still counts when it is the last one of the scan.
   assign scan_hit  = hit_valid | cur_hit;
   assign scan_code = hit_valid ? hit_code : cur_code;
   assign dcnt_inc  = {1'b0, dcnt} + 1'b1;
   assign key_down  = (state == HELD) || (state == RELEASE_WAIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_meta  <= 4'hF;
         row_sync  <= 4'hF;
         cnt       <= '0;
         col_idx   <= 2'd0;
         col       <= 4'b1110;
         hit_valid <= 1'b0;
         hit_code  <= 4'h0;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
         if (tc) begin
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
            col     <= ~(4'b0001 << (col_idx + 2'd1));
            if (col_idx == 2'd3) begin
               hit_valid <= 1'b0;
               hit_code  <= 4'h0;
            end else if (cur_hit && !hit_valid) begin
               hit_valid <= 1'b1;
               hit_code  <= cur_code;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      dcnt_nx  = dcnt;
      accept   = 1'b0;
      if (scan_done) begin
         case (state)
            IDLE: begin
               if (scan_hit) begin
                  cand_nx = scan_code;
                  dcnt_nx = DW'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     accept   = 1'b1;
                     state_nx = HELD;
                  end else begin
                     state_nx = PRESS_WAIT;
                  end
               end
            end
            PRESS_WAIT: begin
               if (!scan_hit) begin
                  state_nx = IDLE;
                  dcnt_nx  = '0;
               end else if (scan_code == cand) begin
                  if (dcnt_inc >= DS_W) begin
                     accept   = 1'b1;
                     state_nx = HELD;
                  end else begin
                     dcnt_nx = dcnt_inc[DW-1:0];
                  end
               end else begin
                  cand_nx = scan_code;
                  dcnt_nx = DW'(1);
               end
            end
            HELD: begin
               if (!scan_hit) begin
                  state_nx = RELEASE_WAIT;
                  dcnt_nx  = DW'(1);
               end
            end
            default: begin
               if (scan_hit) begin
                  state_nx = HELD;
               end else if (dcnt_inc >= DS_W) begin
                  state_nx = IDLE;
                  dcnt_nx  = '0;
               end else begin
                  dcnt_nx = dcnt_inc[DW-1:0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cand      <= 4'h0;
         dcnt      <= '0;
         key       <= 4'h0;
         key_valid <= 1'b0;
         value     <= 16'h0000;
      end else begin
         state     <= state_nx;
         cand      <= cand_nx;
         dcnt      <= dcnt_nx;
         key_valid <= accept;
         if (accept) begin
            key   <= cand_nx;
            value <= clear ? {12'h000, cand_nx} : {value[11:0], cand_nx};
         end else if (clear) begin
            value <= 16'h0000;
         end
      end
   end

endmodule

// File: doc/keypad_scan4x4.md
Name: keypad_scan4x4

Overview:
Scans a 4x4 hex matrix keypad, debounces it, and returns a clean hex key code. It is the input-side mate of the multiplexed 4-digit seven-segment display driver. Both blocks time-multiplex four lines: the display drives four anodes, while this block drives four columns and reads four rows. Accepted keys shift into a 16-bit register whose output connects directly to the display driver's 16-bit data input.

Parameters:
SCAN_DIV, 250000, clock cycles each column is driven (dwell); must be >= 4
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a press or release; must be >= 1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous clear of value
row  input  4  keypad rows, active-low (pulled up), asynchronous to clk
col  output  4  keypad column drive, active-low one-hot
key  output  4  code of most recently accepted key
key_valid  output  1  one-cycle pulse when a key is accepted
key_down  output  1  high while the accepted key is considered held
value  output  16  last four accepted keys, newest in [3:0]

Behaviour:
- Reset (reset=0, async) sets:
  - col=4'b1110, column index 0, dwell counter 0
  - value=0, key=0, key_valid=0, key_down=0
  - FSM=IDLE, candidate=0, debounce count 0
  - row synchronizer flops=4'b1111
- Row input: passes through a 2-flop synchronizer before any use.
- Dwell counter: counts 0..SCAN_DIV-1 and wraps.
- Terminal count (counter==SCAN_DIV-1), on that edge:
  - sample the synchronized row for the current column
  - advance column index, wrapping 3->0
  - col = ~(1<<index)
- Scan order: column 0,1,2,3. The first hit in scan order wins. Within a column, the lowest row index wins.
- Key map, row r / column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Scan result: at the terminal-count edge of column 3, the scan result is either the winning code or NONE. The per-scan hit latch then clears.
- FSM evaluates once per scan, on the column-3 terminal-count edge:
  - IDLE:
    - key k -> candidate=k, count=1, go to PRESS_WAIT
    - if DEBOUNCE_SCANS==1, accept immediately instead
  - PRESS_WAIT:
    - same key -> count+1; when count reaches DEBOUNCE_SCANS, accept
    - different key -> candidate=new key, count=1
    - NONE -> IDLE
  - Accept, all on the same edge:
    - key<=candidate
    - value<={value[11:0],candidate}
    - key_valid=1 for exactly the next cycle
    - go to HELD
  - HELD:
    - any key, including a different one -> stay; no auto-repeat, no new pulse
    - NONE -> RELEASE_WAIT, count=1
  - RELEASE_WAIT:
    - NONE -> count+1; when count reaches DEBOUNCE_SCANS -> IDLE
    - any key -> HELD
- key_down = (state==HELD || state==RELEASE_WAIT).
- clear (synchronous, any cycle): value<=0; FSM, key and scan are unaffected. If clear and accept occur on the same edge, value<={12'h000,candidate}.
- Reset asserted mid-operation aborts any pending press. No key_valid is produced, and all registers return to their reset values.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2, giving a scan period of 16 cycles.
1. Reset, then release with rows idle (4'b1111):
   - during reset: col=1110, all outputs 0
   - after release: col steps 1110->1101->1011->0111->1110 every 4 cycles
   - key_valid never asserts
2. Hold key 5 (row1 low while col=1101) for 5 scans:
   - exactly one key_valid pulse, at the end of scan 2
   - key=4'h5, value=16'h0005
   - key_down high until 2 NONE scans after release
3. Press and release 1, 2, 3, A in sequence:
   - value=16'h123A after four pulses
   - then press 0: value=16'h23A0
4. Bounce cases:
   - key 7 present for 1 scan only -> no pulse, FSM returns to IDLE
   - during a hold of 9, a 1-scan release glitch -> no second pulse, key_down stays high
5. Keys 1 and D pressed together for 3 scans:
   - key=4'h1, one pulse
   - release D only -> no new pulse
6. Mid-operation control:
   - clear asserted during HELD -> value=0, key and key_down unchanged
   - reset pulsed low during PRESS_WAIT -> all outputs return to reset values immediately, no key_valid
